// File: rtl/vector_result_packer.sv
// Packs NUM scalar dot-product results into wide words, buffers them in a small FIFO
// and grants issue credits upstream. Optional perf counters: VECTOR_RESULT_PACKER_PERF_EN.
module vector_result_packer #(
  parameter int NUM   = 16,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic                       res_valid,
  input  logic [DW-1:0]              res_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM*DW-1:0]          out_data,
  output logic [$clog2(NUM+1)-1:0]   out_count,
  output logic                       overflow_err
`ifdef VECTOR_RESULT_PACKER_PERF_EN
  ,
  output logic [31:0]                perf_words,
  output logic [31:0]                perf_stall,
  input  logic                       perf_clear
`endif
);
  localparam int CNTW = $clog2(NUM+1);
  localparam int LW   = $clog2(NUM);
  localparam int CW   = $clog2(DEPTH*NUM+1);
  localparam int FCW  = $clog2(DEPTH+1);
  localparam int PW   = $clog2(DEPTH);

  typedef logic [NUM-1:0][DW-1:0] word_t;

  word_t            pack_q, pack_d, push_word;
  logic [CNTW-1:0]  pack_cnt_q, pack_cnt_d, push_cnt;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic [PW-1:0]    wr_q, rd_q;
  logic             flush_pend_q, flush_pend_d, flush_pend_n;
  logic             err_q, err_d, rdy_q, rdy_d;
  logic             fire, res_ok, push, pop;
  logic [LW-1:0]    lane;
  logic [CW:0]      used, room;
  word_t            mem_q [DEPTH];
  logic [CNTW-1:0]  mcnt_q [DEPTH];

  always_comb begin
    fire         = issue_valid && rdy_q;
    res_ok       = res_valid && (inflight_q != '0);
    out_valid    = (fcnt_q != '0);
    pop          = out_valid && out_ready;
    lane         = pack_cnt_q[LW-1:0];
    pack_d       = pack_q;
    pack_cnt_d   = pack_cnt_q;
    push         = 1'b0;
    push_word    = pack_q;
    push_cnt     = pack_cnt_q;
    inflight_d   = inflight_q + CW'(fire) - CW'(res_ok);
    flush_pend_n = flush_pend_q | flush;
    flush_pend_d = flush_pend_n;
    // Unfilled lanes of pack_q are always zero, so partial words need no masking.
    if (res_ok) begin
      pack_d[lane] = res_data;
      pack_cnt_d   = pack_cnt_q + 1'b1;
    end
    if (pack_cnt_d == CNTW'(NUM)) begin
      push       = 1'b1;
      push_word  = pack_d;
      push_cnt   = CNTW'(NUM);
      pack_d     = '0;
      pack_cnt_d = '0;
    end
    // A flush waits until every launched result has been packed.
    if (flush_pend_n && (inflight_d == '0)) begin
      flush_pend_d = 1'b0;
      if (pack_cnt_d != '0) begin
        push       = 1'b1;
        push_word  = pack_d;
        push_cnt   = pack_cnt_d;
        pack_d     = '0;
        pack_cnt_d = '0;
      end
    end
    fcnt_d = fcnt_q + FCW'(push) - FCW'(pop);
    used   = {1'b0, inflight_d} + (CW+1)'(pack_cnt_d);
    room   = (CW+1)'((DEPTH - int'(fcnt_d)) * NUM);
    rdy_d  = !flush_pend_d && (room > used);
    err_d  = err_q | (issue_valid && !rdy_q) | (res_valid && (inflight_q == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q       <= '0;
      pack_cnt_q   <= '0;
      inflight_q   <= '0;
      fcnt_q       <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      flush_pend_q <= 1'b0;
      err_q        <= 1'b0;
      rdy_q        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]  <= '0;
        mcnt_q[i] <= '0;
      end
    end else begin
      pack_q       <= pack_d;
      pack_cnt_q   <= pack_cnt_d;
      inflight_q   <= inflight_d;
      fcnt_q       <= fcnt_d;
      flush_pend_q <= flush_pend_d;
      err_q        <= err_d;
      rdy_q        <= rdy_d;
      if (push) begin
        mem_q[wr_q]  <= push_word;
        mcnt_q[wr_q] <= push_cnt;
        wr_q         <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  assign issue_ready  = rdy_q;
  assign overflow_err = err_q;
  assign out_data     = out_valid ? mem_q[rd_q]  : '0;
  assign out_count    = out_valid ? mcnt_q[rd_q] : '0;

`ifdef VECTOR_RESULT_PACKER_PERF_EN
  logic [31:0] perf_words_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_words_q <= '0;
      perf_stall_q <= '0;
    end else if (perf_clear) begin
      perf_words_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (pop && (perf_words_q != '1)) perf_words_q <= perf_words_q + 1'b1;
      if (issue_valid && !rdy_q && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_words = perf_words_q;
  assign perf_stall = perf_stall_q;
`endif
endmodule
